// File: rtl/adder_sweep_checker_if.sv
// Bus between the sweep checker and the adder stage under test.
// Handshake, operand/result bytes and sweep statistics in one bundle.
interface adder_sweep_checker_if;
    logic       start;
    logic       abort;
    logic [7:0] operand;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic       fail_seen;
    logic [7:0] first_fail_vec;
    logic [4:0] first_fail_res;

    // master: the sweep checker itself
    modport master (
        input  start, abort, result,
        output operand, busy, done, pass, err_count,
               fail_seen, first_fail_vec, first_fail_res
    );

    // slave: the controller plus the adder being exercised
    modport slave (
        output start, abort, result,
        input  operand, busy, done, pass, err_count,
               fail_seen, first_fail_vec, first_fail_res
    );
endinterface

// File: rtl/adder_sweep_checker.sv
// Sweeps all 256 {b,a} nibble pairs into a 4-bit adder, holds each for SETTLE_CYCLES,
// and checks the 5-bit result against a+b, keeping an error count and the first failure.
module adder_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    adder_sweep_checker_if.master bus
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       operand_q, operand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       err_count_q, err_count_d;
    logic             fail_seen_q, fail_seen_d;
    logic [7:0]       first_fail_vec_q, first_fail_vec_d;
    logic [4:0]       first_fail_res_q, first_fail_res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic [4:0] exp_sum;
    logic       mismatch;
    logic       unused_res_hi;

    // Upper result bits carry nothing the check cares about
    assign unused_res_hi = ^bus.result[7:5];

    assign exp_sum  = 5'(operand_q[3:0]) + 5'(operand_q[7:4]);
    assign mismatch = (bus.result[4:0] != exp_sum);

    always_comb begin
        state_d          = state_q;
        operand_d        = operand_q;
        cnt_d            = cnt_q;
        err_count_d      = err_count_q;
        fail_seen_d      = fail_seen_q;
        first_fail_vec_d = first_fail_vec_q;
        first_fail_res_d = first_fail_res_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d          = ST_DRIVE;
                    operand_d        = 8'h00;
                    cnt_d            = '0;
                    err_count_d      = 9'd0;
                    fail_seen_d      = 1'b0;
                    first_fail_vec_d = 8'h00;
                    first_fail_res_d = 5'h00;
                end
            end
            ST_DRIVE: begin
                // Abort wins over a compare landing in the same cycle
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    if (mismatch) begin
                        err_count_d = err_count_q + 9'd1;
                        if (!fail_seen_q) begin
                            fail_seen_d      = 1'b1;
                            first_fail_vec_d = operand_q;
                            first_fail_res_d = bus.result[4:0];
                        end
                    end
                    if (operand_q != 8'hFF) begin
                        operand_d = operand_q + 8'd1;
                        cnt_d     = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status flags follow the next state so they line up with it
        busy_d = (state_d == ST_DRIVE);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_count_d == 9'd0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q          <= ST_IDLE;
            operand_q        <= 8'h00;
            cnt_q            <= '0;
            err_count_q      <= 9'd0;
            fail_seen_q      <= 1'b0;
            first_fail_vec_q <= 8'h00;
            first_fail_res_q <= 5'h00;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            operand_q        <= operand_d;
            cnt_q            <= cnt_d;
            err_count_q      <= err_count_d;
            fail_seen_q      <= fail_seen_d;
            first_fail_vec_q <= first_fail_vec_d;
            first_fail_res_q <= first_fail_res_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
        end
    end

    assign bus.operand        = operand_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_count_q;
    assign bus.fail_seen      = fail_seen_q;
    assign bus.first_fail_vec = first_fail_vec_q;
    assign bus.first_fail_res = first_fail_res_q;

endmodule
